// File: rtl/mux_pkg.sv
// Shared encodings for the 2-1 mux arbiter: FSM state codes and mux select values.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN1 = 2'b01,
        ST_OWN2 = 2'b10
    } state_t;

    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/mux21_sw.sv
// 1-bit 2-1 multiplexer datapath: ctrl=0 passes in1, ctrl=1 passes in2.
module mux21_sw (
    input  logic in1,
    input  logic in2,
    input  logic ctrl,
    output logic out
);

    assign out = ctrl ? in2 : in1;

endmodule

// File: rtl/mux21_arb.sv
// Two-requester round-robin arbiter owning the select of a shared mux21_sw.
// Ownership is bounded by MAX_HOLD cycles whenever the other side is waiting.
module mux21_arb #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    input  logic in1,
    input  logic in2,
    output logic gnt1,
    output logic gnt2,
    output logic ctrl,
    output logic out,
    output logic busy
);
    import mux_pkg::*;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_q,  hold_d;
    logic             last_q,  last_d;
    logic             ctrl_q,  ctrl_d;
    logic             gnt1_q,  gnt1_d;
    logic             gnt2_q,  gnt2_d;

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        last_d  = last_q;
        ctrl_d  = ctrl_q;

        case (state_q)
            ST_IDLE: begin
                // On contention, last_q=1 means source 2 owned last, so source 1 wins.
                if (req1 && req2)
                    state_d = last_q ? ST_OWN1 : ST_OWN2;
                else if (req1)
                    state_d = ST_OWN1;
                else if (req2)
                    state_d = ST_OWN2;
            end
            ST_OWN1: begin
                if (!req1)
                    state_d = req2 ? ST_OWN2 : ST_IDLE;
                else if (req2 && hold_q == HOLD_MAX)
                    state_d = ST_OWN2;
            end
            ST_OWN2: begin
                if (!req2)
                    state_d = req1 ? ST_OWN1 : ST_IDLE;
                else if (req1 && hold_q == HOLD_MAX)
                    state_d = ST_OWN1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != ST_IDLE && state_d == state_q)
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + CNT_W'(1);

        // In IDLE the select is left alone so out does not glitch on release.
        if (state_d == ST_OWN1) begin
            last_d = 1'b0;
            ctrl_d = SEL_IN1;
        end else if (state_d == ST_OWN2) begin
            last_d = 1'b1;
            ctrl_d = SEL_IN2;
        end

        gnt1_d = (state_d == ST_OWN1);
        gnt2_d = (state_d == ST_OWN2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            last_q  <= 1'b1;
            ctrl_q  <= SEL_IN1;
            gnt1_q  <= 1'b0;
            gnt2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            ctrl_q  <= ctrl_d;
            gnt1_q  <= gnt1_d;
            gnt2_q  <= gnt2_d;
        end
    end

    assign gnt1 = gnt1_q;
    assign gnt2 = gnt2_q;
    assign ctrl = ctrl_q;
    assign busy = gnt1_q | gnt2_q;

    mux21_sw u_mux (
        .in1  (in1),
        .in2  (in2),
        .ctrl (ctrl_q),
        .out  (out)
    );

endmodule

// File: tb/tb_mux21_arb.sv
// Self-checking bench for mux21_arb: two instances (MAX_HOLD=4 and MAX_HOLD=1) against an owner/run-length model.
module tb_mux21_arb;

    logic clk;
    logic rst;
    logic req1;
    logic req2;
    logic in1;
    logic in2;

    logic gnt1A, gnt2A, ctrlA, outA, busyA;
    logic gnt1B, gnt2B, ctrlB, outB, busyB;

    int checks;
    int failures;

    int   ownerM  [2];
    int   runM    [2];
    int   lastM   [2];
    logic ctrlM   [2];
    int   maxHold [2];

    logic [15:0] logA, logB, logModelA, logModelB;
    logic [15:0] expLogA, expLogB;

    mux21_arb #(.MAX_HOLD(4), .CNT_W(4)) dutA (
        .clk  (clk),
        .rst  (rst),
        .req1 (req1),
        .req2 (req2),
        .in1  (in1),
        .in2  (in2),
        .gnt1 (gnt1A),
        .gnt2 (gnt2A),
        .ctrl (ctrlA),
        .out  (outA),
        .busy (busyA)
    );

    mux21_arb #(.MAX_HOLD(1), .CNT_W(2)) dutB (
        .clk  (clk),
        .rst  (rst),
        .req1 (req1),
        .req2 (req2),
        .in1  (in1),
        .in2  (in2),
        .gnt1 (gnt1B),
        .gnt2 (gnt2B),
        .ctrl (ctrlB),
        .out  (outB),
        .busy (busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Model: who owns the line, how many cycles in a row it has owned it, and who owned last.
    task automatic modelStep(input int k);
        int nxt;
        int other;
        logic mine;
        logic theirs;
        if (rst) begin
            ownerM[k] = 0;
            runM[k]   = 0;
            lastM[k]  = 2;
            ctrlM[k]  = 1'b0;
            return;
        end
        if (ownerM[k] == 0) begin
            if (req1 && req2)  nxt = (lastM[k] == 1) ? 2 : 1;
            else if (req1)     nxt = 1;
            else if (req2)     nxt = 2;
            else               nxt = 0;
        end else begin
            other  = 3 - ownerM[k];
            mine   = (ownerM[k] == 1) ? req1 : req2;
            theirs = (ownerM[k] == 1) ? req2 : req1;
            if (!mine)                              nxt = theirs ? other : 0;
            else if (theirs && runM[k] >= maxHold[k]) nxt = other;
            else                                    nxt = ownerM[k];
        end
        if (nxt != 0 && nxt == ownerM[k]) runM[k] = runM[k] + 1;
        else                              runM[k] = (nxt != 0) ? 1 : 0;
        if (nxt != 0) lastM[k] = nxt;
        if (nxt == 1) ctrlM[k] = 1'b0;
        if (nxt == 2) ctrlM[k] = 1'b1;
        ownerM[k] = nxt;
    endtask

    task automatic checkOutput();
        logic expOutA, expOutB;
        expOutA = ctrlM[0] ? in2 : in1;
        expOutB = ctrlM[1] ? in2 : in1;
        checkBit("A.gnt1", gnt1A, ownerM[0] == 1);
        checkBit("A.gnt2", gnt2A, ownerM[0] == 2);
        checkBit("A.ctrl", ctrlA, ctrlM[0]);
        checkBit("A.out",  outA,  expOutA);
        checkBit("A.busy", busyA, ownerM[0] != 0);
        checkBit("B.gnt1", gnt1B, ownerM[1] == 1);
        checkBit("B.gnt2", gnt2B, ownerM[1] == 2);
        checkBit("B.ctrl", ctrlB, ctrlM[1]);
        checkBit("B.out",  outB,  expOutB);
        checkBit("B.busy", busyB, ownerM[1] != 0);
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model, compare.
    task automatic applyStimulus(input logic r, input logic r1, input logic r2,
                                 input logic i1, input logic i2);
        rst  = r;
        req1 = r1;
        req2 = r2;
        in1  = i1;
        in2  = i2;
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        checkOutput();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        maxHold[0] = 4;
        maxHold[1] = 1;
        for (int k = 0; k < 2; k++) begin
            ownerM[k] = 0;
            runM[k]   = 0;
            lastM[k]  = 2;
            ctrlM[k]  = 1'b0;
        end
        rst = 1'b1; req1 = 1'b1; req2 = 1'b1; in1 = 1'b0; in2 = 1'b1;

        $display("[TB] reset with both requesting");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkBit("rst.gnt1", gnt1A, 1'b0);
        checkBit("rst.gnt2", gnt2A, 1'b0);
        checkBit("rst.ctrl", ctrlA, 1'b0);

        $display("[TB] continuous contention");
        logA = '0; logB = '0; logModelA = '0; logModelB = '0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, c[0], ~c[0]);
            if (c == 0) begin
                checkBit("release.gnt1", gnt1A, 1'b1);
                checkBit("release.ctrl", ctrlA, 1'b0);
            end
            logA      = {logA[14:0], ctrlA};
            logB      = {logB[14:0], ctrlB};
            logModelA = {logModelA[14:0], ctrlM[0]};
            logModelB = {logModelB[14:0], ctrlM[1]};
        end
        expLogA = 16'b0000111100001111;
        expLogB = 16'b0101010101010101;
        checkWord("rotate4.dut",   logA,      expLogA);
        checkWord("rotate4.model", logModelA, expLogA);
        checkWord("rotate1.dut",   logB,      expLogB);
        checkWord("rotate1.model", logModelB, expLogB);

        $display("[TB] single requester, then release");
        for (int c = 0; c < 4; c++)
            applyStimulus(1'b0, 1'b1, 1'b0, c[0], 1'b1);
        checkBit("solo.gnt1", gnt1A, 1'b1);
        checkBit("solo.out",  outA,  1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkBit("idle.busy", busyA, 1'b0);
        checkBit("idle.ctrl", ctrlA, 1'b0);
        checkBit("idle.out",  outA,  1'b0);

        $display("[TB] direct handoff");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkBit("handoff.gnt1", gnt1A, 1'b0);
        checkBit("handoff.gnt2", gnt2A, 1'b1);
        checkBit("handoff.out",  outA,  1'b1);

        $display("[TB] saturated owner, late contender");
        for (int c = 0; c < 10; c++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkBit("sat.gnt2", gnt2A, 1'b1);
        checkBit("sat.ctrl", ctrlA, 1'b1);

        $display("[TB] reset while source 2 owns");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkBit("midrst.gnt1", gnt1A, 1'b0);
        checkBit("midrst.gnt2", gnt2A, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkBit("midrst.regrant", gnt1A, 1'b1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
